// File: rtl/if_fetch_queue_pkg.sv
// Shared types and width helpers for the instruction fetch queue.
package if_pkg;

  localparam int INST_BYTES = 4;
  localparam int FQ_XLEN    = 32;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [31:0]        ir;
    logic               filled;
  } fq_entry_t;

  // Ring pointer width; DEPTH is a power of two so pointers wrap for free.
  function automatic int fq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int fq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: EX redirect, instruction-memory handshake, decode handshake.
interface if_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             ex_take_branch_out;
  logic [XLEN-1:0]  ex_target_PC_out;
  logic             proc2Imem_req;
  logic [XLEN-1:0]  proc2Imem_addr;
  logic             Imem2proc_req_ready;
  logic             Imem2proc_valid;
  logic [31:0]      Imem2proc_data;
  logic             if_valid_inst_out;
  logic             id_ready_in;
  logic [XLEN-1:0]  if_PC_out;
  logic [XLEN-1:0]  if_NPC_out;
  logic [31:0]      if_IR_out;
  logic [CNT_W-1:0] if_count_out;

  modport master (
    input  ex_take_branch_out, ex_target_PC_out, Imem2proc_req_ready,
           Imem2proc_valid, Imem2proc_data, id_ready_in,
    output proc2Imem_req, proc2Imem_addr, if_valid_inst_out,
           if_PC_out, if_NPC_out, if_IR_out, if_count_out
  );

  modport slave (
    output ex_take_branch_out, ex_target_PC_out, Imem2proc_req_ready,
           Imem2proc_valid, Imem2proc_data, id_ready_in,
    input  proc2Imem_req, proc2Imem_addr, if_valid_inst_out,
           if_PC_out, if_NPC_out, if_IR_out, if_count_out
  );

endinterface

// File: rtl/if_fetch_queue_fetch_ring.sv
// Ring of fetch entries: allocate at tail, fill oldest unfilled, pop head, flush all.
module fetch_ring
  import if_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        alloc_i,
  input  logic [XLEN-1:0]             alloc_pc_i,
  input  logic                        fill_i,
  input  logic [31:0]                 fill_ir_i,
  input  logic                        pop_i,
  output logic                        head_valid_o,
  output logic [XLEN-1:0]             head_pc_o,
  output logic [31:0]                 head_ir_o,
  output logic [fq_cnt_w(DEPTH)-1:0]  count_o,
  output logic [fq_cnt_w(DEPTH)-1:0]  pend_o
);
  localparam int PTR_W = fq_ptr_w(DEPTH);
  localparam int CNT_W = fq_cnt_w(DEPTH);

  // Same layout as fq_entry_t, but sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic            filled;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d, pend_q, pend_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    pend_d  = pend_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      pend_d  = '0;
    end else begin
      if (alloc_i) tail_d = tail_q + PTR_W'(1);
      if (fill_i)  fill_d = fill_q + PTR_W'(1);
      if (pop_i)   head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
      pend_d  = pend_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  // Alloc targets a free slot and fill an allocated one, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].filled <= 1'b0;
    end else begin
      if (alloc_i) begin
        ent_q[tail_q].pc     <= alloc_pc_i;
        ent_q[tail_q].filled <= 1'b0;
      end
      if (fill_i) begin
        ent_q[fill_q].ir     <= fill_ir_i;
        ent_q[fill_q].filled <= 1'b1;
      end
    end
  end

  assign head_valid_o = (count_q != '0) & ent_q[head_q].filled;
  assign head_pc_o    = (count_q != '0) ? ent_q[head_q].pc : '0;
  assign head_ir_o    = (count_q != '0) ? ent_q[head_q].ir : '0;
  assign count_o      = count_q;
  assign pend_o       = pend_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues Imem requests, matches in-order responses to
// queued PCs and feeds decode; a taken branch flushes, redirects and drops stale data.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_queue_if.master fq
);
  localparam int CNT_W = fq_cnt_w(DEPTH);
  localparam int INF_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count, pend;
  logic             head_valid;
  logic [XLEN-1:0]  head_pc;
  logic [31:0]      head_ir;
  logic             branch, resp, can_issue, req, accept;
  logic             valid_out, pop, fill;
  logic [INF_W-1:0] inflight;
  logic             unused_tgt_lo;

  assign branch = fq.ex_take_branch_out;
  assign resp   = fq.Imem2proc_valid;

  // Stale responses still owed occupy capacity until memory returns them.
  assign inflight  = INF_W'(count) + INF_W'(drop_q);
  assign can_issue = inflight < INF_W'(DEPTH);
  assign req       = can_issue & ~branch & ~rst;
  assign accept    = req & fq.Imem2proc_req_ready;
  assign valid_out = head_valid & ~branch;
  assign pop       = valid_out & fq.id_ready_in;
  assign fill      = resp & ~branch & (drop_q == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (branch) begin
      fetch_pc_d = {fq.ex_target_PC_out[XLEN-1:2], 2'b00};
      drop_d     = drop_q + pend - CNT_W'(resp);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
      if (resp && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  fetch_ring #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (branch),
    .alloc_i      (accept),
    .alloc_pc_i   (fetch_pc_q),
    .fill_i       (fill),
    .fill_ir_i    (fq.Imem2proc_data),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_pc_o    (head_pc),
    .head_ir_o    (head_ir),
    .count_o      (count),
    .pend_o       (pend)
  );

  assign unused_tgt_lo = ^fq.ex_target_PC_out[1:0];

  assign fq.proc2Imem_req     = req;
  assign fq.proc2Imem_addr    = {fetch_pc_q[XLEN-1:2], 2'b00};
  assign fq.if_valid_inst_out = valid_out;
  assign fq.if_PC_out         = head_pc;
  assign fq.if_NPC_out        = (count != '0) ? head_pc + XLEN'(INST_BYTES) : '0;
  assign fq.if_IR_out         = head_ir;
  assign fq.if_count_out      = count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-level reference model
// and an in-order instruction memory with variable latency.
module tb_if_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq ();

  if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    bit          filled;
  } ment_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  ment_t       mq[$];
  mreq_t       memq[$];
  logic [31:0] m_pc;
  int          m_drop;
  int          cyc, last_due;
  int          n_chk, n_fail;

  int          p_ready, p_id, p_br, lat_min, lat_max;
  bit          force_br;
  logic [31:0] force_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic knobs(input int rdy, input int idr, input int lmin, input int lmax, input int br);
    p_ready = rdy;
    p_id    = idr;
    lat_min = lmin;
    lat_max = lmax;
    p_br    = br;
  endtask

  task automatic do_reset(input bit mid);
    if (mid) begin
      @(negedge clk);
      #2;
    end
    rst = 1'b1;
    fq.ex_take_branch_out  = 1'b0;
    fq.ex_target_PC_out    = '0;
    fq.Imem2proc_req_ready = 1'b0;
    fq.Imem2proc_valid     = 1'b0;
    fq.Imem2proc_data      = '0;
    fq.id_ready_in         = 1'b0;
    #1;
    check_eq("rst_req",   fq.proc2Imem_req,     0);
    check_eq("rst_valid", fq.if_valid_inst_out, 0);
    check_eq("rst_count", fq.if_count_out,      0);
    check_eq("rst_pc",    fq.if_PC_out,         0);
    check_eq("rst_npc",   fq.if_NPC_out,        0);
    check_eq("rst_ir",    fq.if_IR_out,         0);
    mq.delete();
    memq.delete();
    m_drop   = 0;
    m_pc     = RESET_PC;
    last_due = cyc;
    @(posedge clk);
  endtask

  task automatic step();
    bit          rdy, idr, br, resp, exp_req, exp_valid;
    logic [31:0] tgt, data;
    int          unf, fidx, due;

    @(negedge clk);
    rst = 1'b0;
    cyc++;
    rdy  = ($urandom_range(99) < p_ready);
    idr  = ($urandom_range(99) < p_id);
    br   = force_br || ($urandom_range(999) < p_br);
    tgt  = force_br ? force_tgt :
           (($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom);
    resp = (memq.size() > 0) && (memq[0].due <= cyc);
    data = resp ? mem_word(memq[0].addr) : $urandom;
    if (resp) void'(memq.pop_front());

    fq.Imem2proc_req_ready = rdy;
    fq.id_ready_in         = idr;
    fq.ex_take_branch_out  = br;
    fq.ex_target_PC_out    = tgt;
    fq.Imem2proc_valid     = resp;
    fq.Imem2proc_data      = data;
    #1;

    unf = 0;
    foreach (mq[i]) if (!mq[i].filled) unf++;
    exp_req   = (mq.size() + m_drop < DEPTH) && !br;
    exp_valid = (mq.size() > 0) && mq[0].filled && !br;

    check_eq("req", fq.proc2Imem_req, exp_req);
    if (exp_req) check_eq("addr", fq.proc2Imem_addr, m_pc);
    check_eq("valid", fq.if_valid_inst_out, exp_valid);
    check_eq("count", fq.if_count_out, mq.size());
    if (exp_valid) begin
      check_eq("pc",  fq.if_PC_out,  mq[0].pc);
      check_eq("npc", fq.if_NPC_out, mq[0].pc + 32'd4);
      check_eq("ir",  fq.if_IR_out,  mq[0].ir);
    end
    if (resp) check_eq("resp_owed", (m_drop + unf) > 0, 1'b1);

    // Memory takes whatever the DUT actually requests, returning in order.
    if (fq.proc2Imem_req && rdy) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      memq.push_back('{addr: fq.proc2Imem_addr, due: due});
      last_due = due;
    end

    if (br) begin
      m_drop = m_drop + unf - int'(resp);
      mq.delete();
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      if (resp) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          fidx = -1;
          foreach (mq[i]) if (!mq[i].filled && fidx < 0) fidx = i;
          if (fidx >= 0) begin
            mq[fidx].ir     = data;
            mq[fidx].filled = 1'b1;
          end
        end
      end
      if (exp_valid && idr) void'(mq.pop_front());
      if (exp_req && rdy) begin
        mq.push_back('{pc: m_pc, ir: 32'h0, filled: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    force_br = 1'b0;
    force_tgt = '0;
    knobs(100, 100, 1, 1, 0);
    #1;
    do_reset(1'b0);

    // streaming, latency 1
    repeat (30) step();

    // back-pressure until full, then drain
    knobs(100, 0, 1, 1, 0);
    repeat (10) step();
    knobs(100, 100, 1, 1, 0);
    repeat (15) step();

    // redirect with responses in flight and a dequeue pending
    knobs(100, 100, 3, 3, 0);
    repeat (12) step();
    force_br = 1'b1; force_tgt = 32'h0000_0103;
    step();
    force_br = 1'b0;
    repeat (15) step();

    // PC wrap across 2^32
    knobs(100, 100, 1, 1, 0);
    force_br = 1'b1; force_tgt = 32'hFFFF_FFF8;
    step();
    force_br = 1'b0;
    repeat (12) step();

    // random traffic
    knobs(70, 70, 1, 5, 60);
    repeat (3000) step();
    knobs(90, 40, 1, 3, 20);
    repeat (1000) step();

    // asynchronous reset mid-stream, then restart from RESET_PC
    knobs(100, 100, 2, 2, 0);
    repeat (8) step();
    do_reset(1'b1);
    repeat (15) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
